// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: grants one write per cycle in age order,
// coalesces same-rd writes, parks losers in a small queue and forwards queued data.

module rf_wr_arb_slot #(
    parameter int XLEN = 32
) (
    input  logic            vld_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [4:0]      alu_rd_i,
    output logic            wb_hit_o,
    output logic            alu_hit_o,
    output logic            rs1_hit_o,
    output logic            rs2_hit_o,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] rs2_val_o
);
    assign wb_hit_o  = vld_i && (rd_i == wb_rd_i);
    assign alu_hit_o = vld_i && (rd_i == alu_rd_i);
    assign rs1_hit_o = vld_i && (rd_i == rs1_i) && (rs1_i != 5'd0);
    assign rs2_hit_o = vld_i && (rd_i == rs2_i) && (rs2_i != 5'd0);
    assign rs1_val_o = rs1_hit_o ? data_i : '0;
    assign rs2_val_o = rs2_hit_o ? data_i : '0;
endmodule

module rf_wr_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_reg_w_en,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_out,
    input  logic            wb_en,
    input  logic [4:0]      wb_reg,
    input  logic [XLEN-1:0] wb_val,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd1_val,
    output logic [XLEN-1:0] fwd2_val,
    output logic            ovf
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] NEAR_C  = CW'(DEPTH - 1);

    logic [DEPTH-1:0]           vld_q, vld_d;
    logic [DEPTH-1:0][4:0]      rd_q, rd_d;
    logic [DEPTH-1:0][XLEN-1:0] data_q, data_d;
    logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;

    logic            we_d, ovf_d;
    logic [4:0]      waddr_d;
    logic [XLEN-1:0] wdata_d;

    logic [DEPTH-1:0]           s_wb_hit, s_alu_hit, s_rs1_hit, s_rs2_hit;
    logic [DEPTH-1:0][XLEN-1:0] s_rs1_val, s_rs2_val;

    logic alu_s, wb_s, alu_pend, wb_pend, alu_push, wb_push, pop, ovf_set;
    logic [CW-1:0] occ;
    logic [PW-1:0] tail;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        rf_wr_arb_slot #(.XLEN(XLEN)) u_slot (
            .vld_i    (vld_q[g]),
            .rd_i     (rd_q[g]),
            .data_i   (data_q[g]),
            .rs1_i    (rs1),
            .rs2_i    (rs2),
            .wb_rd_i  (wb_reg),
            .alu_rd_i (alu_rd),
            .wb_hit_o (s_wb_hit[g]),
            .alu_hit_o(s_alu_hit[g]),
            .rs1_hit_o(s_rs1_hit[g]),
            .rs2_hit_o(s_rs2_hit[g]),
            .rs1_val_o(s_rs1_val[g]),
            .rs2_val_o(s_rs2_val[g])
        );
    end

    // At most one entry per rd exists, so OR-reducing the masked slot data is exact.
    always_comb begin
        fwd1_hit = 1'b0;
        fwd2_hit = 1'b0;
        fwd1_val = '0;
        fwd2_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd1_hit = fwd1_hit | s_rs1_hit[i];
            fwd2_hit = fwd2_hit | s_rs2_hit[i];
            fwd1_val = fwd1_val | s_rs1_val[i];
            fwd2_val = fwd2_val | s_rs2_val[i];
        end
    end

    // Same-rd collision: the younger ALU write supersedes WB.
    assign alu_s    = alu_reg_w_en && (alu_rd != 5'd0);
    assign wb_s     = wb_en && (wb_reg != 5'd0) && !(alu_s && (alu_rd == wb_reg));
    assign wb_pend  = wb_s && !(|s_wb_hit);
    assign alu_pend = alu_s && !(|s_alu_hit);

    always_comb begin
        vld_d    = vld_q;
        rd_d     = rd_q;
        data_d   = data_q;
        we_d     = 1'b0;
        waddr_d  = rf_waddr;
        wdata_d  = rf_wdata;
        wb_push  = 1'b0;
        alu_push = 1'b0;
        pop      = 1'b0;
        ovf_set  = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            if (wb_s && s_wb_hit[i])   data_d[i] = wb_val;
            if (alu_s && s_alu_hit[i]) data_d[i] = alu_out;
        end

        if (count_q != '0) begin
            pop      = 1'b1;
            we_d     = 1'b1;
            waddr_d  = rd_q[head_q];
            wdata_d  = data_d[head_q];
            wb_push  = wb_pend;
            alu_push = alu_pend;
        end else if (wb_pend) begin
            we_d     = 1'b1;
            waddr_d  = wb_reg;
            wdata_d  = wb_val;
            alu_push = alu_pend;
        end else if (alu_pend) begin
            we_d    = 1'b1;
            waddr_d = alu_rd;
            wdata_d = alu_out;
        end

        if (pop) vld_d[head_q] = 1'b0;
        occ  = count_q - CW'(pop);
        tail = tail_q;
        // The freed head slot may be refilled in the same cycle when the queue was full.
        if (wb_push) begin
            if (occ < DEPTH_C) begin
                vld_d[tail]  = 1'b1;
                rd_d[tail]   = wb_reg;
                data_d[tail] = wb_val;
                tail         = ptr_inc(tail);
                occ          = occ + CW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (alu_push) begin
            if (occ < DEPTH_C) begin
                vld_d[tail]  = 1'b1;
                rd_d[tail]   = alu_rd;
                data_d[tail] = alu_out;
                tail         = ptr_inc(tail);
                occ          = occ + CW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end

        head_d  = pop ? ptr_inc(head_q) : head_q;
        tail_d  = tail;
        count_d = occ;
        ovf_d   = ovf | ovf_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q    <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            stall    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rf_we    <= we_d;
            rf_waddr <= waddr_d;
            rf_wdata <= wdata_d;
            stall    <= (count_d >= NEAR_C);
            ovf      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomized bench for rf_wr_arbiter against a queue-based reference model.

module tb_rf_wr_arbiter;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic            clk, rst;
    logic            alu_reg_w_en, wb_en;
    logic [4:0]      alu_rd, wb_reg, rs1, rs2;
    logic [XLEN-1:0] alu_out, wb_val;
    logic            rf_we, stall, fwd1_hit, fwd2_hit, ovf;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata, fwd1_val, fwd2_val;

    rf_wr_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_reg_w_en(alu_reg_w_en), .alu_rd(alu_rd), .alu_out(alu_out),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val),
        .rs1(rs1), .rs2(rs2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall(stall),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_val(fwd1_val), .fwd2_val(fwd2_val),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    ent_t        mq[$];
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fwd_check(input logic [4:0] r1, input logic [4:0] r2);
        bit h1 = 0, h2 = 0;
        logic [31:0] v1 = '0, v2 = '0;
        rs1 = r1;
        rs2 = r2;
        foreach (mq[i]) begin
            if (r1 != 0 && mq[i].rd == r1) begin h1 = 1; v1 = mq[i].d; end
            if (r2 != 0 && mq[i].rd == r2) begin h2 = 1; v2 = mq[i].d; end
        end
        #1;
        chk("fwd1_hit", fwd1_hit, h1);
        chk("fwd1_val", fwd1_val, v1);
        chk("fwd2_hit", fwd2_hit, h2);
        chk("fwd2_val", fwd2_val, v2);
    endtask

    // One clock: drive requests, advance the model by the arbitration rules, compare.
    task automatic step(input bit ae, input logic [4:0] ar, input logic [31:0] ad,
                        input bit we, input logic [4:0] wr, input logic [31:0] wd);
        bit a_s, w_s, e_we;
        alu_reg_w_en = ae; alu_rd = ar; alu_out = ad;
        wb_en = we; wb_reg = wr; wb_val = wd;
        a_s = ae && ar != 0;
        w_s = we && wr != 0 && !(a_s && ar == wr);
        foreach (mq[i]) begin
            if (w_s && mq[i].rd == wr) begin mq[i].d = wd; w_s = 0; end
            if (a_s && mq[i].rd == ar) begin mq[i].d = ad; a_s = 0; end
        end
        e_we = 1;
        if (mq.size() > 0) begin
            ent_t g;
            g = mq.pop_front();
            m_addr = g.rd; m_data = g.d;
        end else if (w_s) begin
            m_addr = wr; m_data = wd; w_s = 0;
        end else if (a_s) begin
            m_addr = ar; m_data = ad; a_s = 0;
        end else begin
            e_we = 0;
        end
        if (w_s) begin
            if (mq.size() < DEPTH) mq.push_back('{rd: wr, d: wd}); else m_ovf = 1;
        end
        if (a_s) begin
            if (mq.size() < DEPTH) mq.push_back('{rd: ar, d: ad}); else m_ovf = 1;
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, e_we);
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
        chk("stall", stall, mq.size() >= DEPTH - 1);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic idle();
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        alu_reg_w_en = 0; alu_rd = 0; alu_out = 0;
        wb_en = 0; wb_reg = 0; wb_val = 0; rs1 = 0; rs2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        #2 rst = 1'b1;

        // single ALU write
        step(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
        chk("single_addr", rf_waddr, 5'd5);
        chk("single_data", rf_wdata, 32'h1234);
        // dual, different rd: ALU deferred and forwardable
        step(1, 5'd4, 32'hB, 1, 5'd3, 32'hA);
        chk("dual_addr", rf_waddr, 5'd3);
        fwd_check(5'd4, 5'd3);
        chk("dual_fwd_val", fwd1_val, 32'hB);
        idle();
        chk("dual_drain", rf_waddr, 5'd4);
        idle();
        // same rd: ALU wins, single write
        step(1, 5'd7, 32'h2, 1, 5'd7, 32'h1);
        chk("same_data", rf_wdata, 32'h2);
        idle();
        // x0 filter
        step(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h1);
        fwd_check(5'd0, 5'd0);
        // coalesce into the head entry
        step(1, 5'd4, 32'hB, 1, 5'd3, 32'hA);
        step(0, 5'd0, 32'd0, 1, 5'd4, 32'hC);
        chk("coal_data", rf_wdata, 32'hC);
        idle();

        // random phase honouring the stall contract
        for (int n = 0; n < 400; n++) begin
            bit ae, we;
            ae = ($urandom_range(0, 2) != 0);
            we = ($urandom_range(0, 2) != 0);
            if (stall && ae && we) begin
                if ($urandom_range(0, 1) != 0) ae = 0; else we = 0;
            end
            step(ae, 5'($urandom_range(0, 9)), $urandom,
                 we, 5'($urandom_range(0, 9)), $urandom);
            fwd_check(5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
        end
        while (mq.size() > 0) idle();

        // overflow: dual distinct writes ignoring stall
        for (int n = 0; n < DEPTH + 2; n++)
            step(1, 5'(10 + 2 * n), 32'(n), 1, 5'(11 + 2 * n), 32'(100 + n));
        chk("ovf_set", ovf, 1'b1);
        fwd_check(5'(11 + 2 * (DEPTH + 1)), 5'd0);
        chk("ovf_full_fwd", fwd1_hit, 1'b1);

        // asynchronous reset in mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("arst_we", rf_we, 1'b0);
        chk("arst_waddr", rf_waddr, 5'd0);
        chk("arst_wdata", rf_wdata, 32'd0);
        chk("arst_stall", stall, 1'b0);
        chk("arst_ovf", ovf, 1'b0);
        mq.delete();
        m_addr = '0; m_data = '0; m_ovf = 0;
        fwd_check(5'(11 + 2 * (DEPTH + 1)), 5'(10 + 2 * DEPTH));
        #1 rst = 1'b1;
        repeat (DEPTH + 2) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
